// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding and bit-period derivation.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones (idle-high lines).
module uart_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  generate
    if (CLKS_PER_BIT < 8) begin : g_cpb_check
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic          rxs;
  logic          rxs_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif

  uart_sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rxs_prev  <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rxs_prev  <= rxs;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          // Edge, not level: a held-low break line must not retrigger.
          if (rxs_prev && !rxs) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (rxs) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (!rxs) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift, par_bit}) begin
              parity_err <= 1'b1;
`endif
            end else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          clk_cnt <= '0;
          bit_idx <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
